// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master: bus width defaults, FSM states and
// the queued command record.
package apb_master_pkg;

  localparam int AMBA_WORD_DEFAULT       = 24;
  localparam int AMBA_ADDR_DEPTH_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic                               write;
    logic [AMBA_ADDR_DEPTH_DEFAULT-1:0] addr;
    logic [AMBA_WORD_DEFAULT-1:0]       wdata;
  } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Two-entry command queue between the host interface and the APB FSM.
// full ignores a same-cycle pop so the host-side ready stays registered-only.
module apb_cmd_fifo
  import apb_master_pkg::*;
#(
  parameter type cmd_rec_t = cmd_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  cmd_rec_t din,
  output cmd_rec_t dout,
  output logic     full,
  output logic     empty
);

  cmd_rec_t   mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_master.sv
// Host-command to APB master bridge with a 2-deep command queue.
// Define APB_PREADY_EN to let the slave stretch ACCESS via PREADY.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int Amba_Word       = AMBA_WORD_DEFAULT,
  parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [Amba_Addr_Depth-1:0] cmd_addr,
  input  logic [Amba_Word-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [Amba_Word-1:0]       rsp_rdata,
  output logic                       busy,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic [Amba_Word-1:0]       PRDATA,
  input  logic                       PREADY
);

  typedef struct packed {
    logic                       write;
    logic [Amba_Addr_Depth-1:0] addr;
    logic [Amba_Word-1:0]       wdata;
  } cmd_rec_t;

  state_t   state;
  state_t   state_nxt;
  cmd_rec_t fifo_in;
  cmd_rec_t head;
  logic     push;
  logic     pop;
  logic     full;
  logic     empty;
  logic     done;
  logic     rd_done;

`ifdef APB_PREADY_EN
  assign done = PREADY;
`else
  logic unused_pready;
  assign unused_pready = PREADY;
  assign done          = 1'b1;
`endif

  assign fifo_in   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !full;
  assign push      = cmd_valid && !rst;

  apb_cmd_fifo #(
    .cmd_rec_t (cmd_rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (done) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_done = (state == ACCESS) && done && !PWRITE;
  assign PSEL    = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign busy    = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= rd_done;
      if (pop) begin
        PWRITE <= head.write;
        PADDR  <= head.addr;
        PWDATA <= head.wdata;
      end
      if (rd_done) begin
        rsp_rdata <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [23:0] cmd_wdata;
  logic        rsp_valid;
  logic [23:0] rsp_rdata;
  logic        busy;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [23:0] PWDATA;
  logic [23:0] PRDATA;
  logic        PREADY;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [23:0] wdata;
    logic [23:0] prdata;
    logic        exp_rsp;
    logic [23:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [23:0] wdata;
  } cmd_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input logic v, input logic w, input logic [11:0] a, input logic [23:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  vec_t tbl [5];
  cmd_s model_q [$];

  initial begin
    logic [23:0] pend_rdata;
    logic        pend_rsp;
    logic        ready_eff;
    cmd_s        c;
    int          n;
    logic [11:0] exp_addr [8];
    logic        exp_sel  [8];
    logic        exp_en   [8];

    tbl[0] = '{1'b1, 12'h000, 24'h000001, 24'h000000, 1'b0, 24'h000000};
    tbl[1] = '{1'b0, 12'h004, 24'h000000, 24'hABCDEF, 1'b1, 24'hABCDEF};
    tbl[2] = '{1'b1, 12'hFFF, 24'hFFFFFF, 24'h123456, 1'b0, 24'hABCDEF};
    tbl[3] = '{1'b0, 12'hFFF, 24'h000000, 24'h000000, 1'b1, 24'h000000};
    tbl[4] = '{1'b0, 12'h800, 24'h000000, 24'h5A5A5A, 1'b1, 24'h5A5A5A};

    rst    = 1'b1;
    PRDATA = '0;
    PREADY = 1'b1;
    drive_cmd(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);

    // single commands from idle: accept at edge N, SETUP N+1, ACCESS N+2, rsp N+3
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, tbl[i].write, tbl[i].addr, tbl[i].wdata);
      PRDATA = tbl[i].prdata;
      tick();
      drive_cmd(1'b0, 1'b0, '0, '0);
      chk("tbl_n_psel", PSEL, 0);
      chk("tbl_n_busy", busy, 1);
      tick();
      chk("tbl_setup_psel", PSEL, 1);
      chk("tbl_setup_penable", PENABLE, 0);
      chk("tbl_setup_paddr", PADDR, tbl[i].addr);
      chk("tbl_setup_pwrite", PWRITE, tbl[i].write);
      if (tbl[i].write) chk("tbl_setup_pwdata", PWDATA, tbl[i].wdata);
      tick();
      chk("tbl_access_psel", PSEL, 1);
      chk("tbl_access_penable", PENABLE, 1);
      chk("tbl_access_paddr", PADDR, tbl[i].addr);
      chk("tbl_access_pwrite", PWRITE, tbl[i].write);
      if (tbl[i].write) chk("tbl_access_pwdata", PWDATA, tbl[i].wdata);
      chk("tbl_access_rsp_valid", rsp_valid, 0);
      tick();
      chk("tbl_done_psel", PSEL, 0);
      chk("tbl_done_rsp_valid", rsp_valid, tbl[i].exp_rsp);
      chk("tbl_done_rsp_rdata", rsp_rdata, tbl[i].exp_rdata);
      chk("tbl_idle_paddr_hold", PADDR, tbl[i].addr);
      tick();
      chk("tbl_after_rsp_valid", rsp_valid, 0);
      chk("tbl_after_rsp_rdata", rsp_rdata, tbl[i].exp_rdata);
      chk("tbl_after_busy", busy, 0);
    end

    // three commands on consecutive cycles, transfers back-to-back
    PRDATA = 24'h0C0FFE;
    drive_cmd(1'b1, 1'b1, 12'h001, 24'h000011);
    tick();
    drive_cmd(1'b1, 1'b1, 12'h002, 24'h000022);
    chk("b2b_ready_1", cmd_ready, 1);
    tick();
    drive_cmd(1'b1, 1'b0, 12'h003, 24'h000000);
    chk("b2b_ready_2", cmd_ready, 1);
    tick();
    drive_cmd(1'b0, 1'b0, '0, '0);
    chk("b2b_ready_full", cmd_ready, 0);
    exp_sel  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_en   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_addr = '{12'h001, 12'h002, 12'h002, 12'h003, 12'h003, 12'h003, 12'h003, 12'h003};
    for (int k = 0; k < 8; k++) begin
      chk("b2b_psel", PSEL, exp_sel[k]);
      chk("b2b_penable", PENABLE, exp_en[k]);
      chk("b2b_paddr", PADDR, exp_addr[k]);
      chk("b2b_rsp_valid", rsp_valid, (k == 5) ? 1 : 0);
      if (k == 5) chk("b2b_rsp_rdata", rsp_rdata, 24'h0C0FFE);
      tick();
    end

`ifdef APB_PREADY_EN
    // slave holds PREADY low for three ACCESS cycles
    PRDATA = 24'h654321;
    PREADY = 1'b0;
    drive_cmd(1'b1, 1'b0, 12'h010, 24'h0);
    tick();
    drive_cmd(1'b0, 1'b0, '0, '0);
    tick();
    chk("wait_setup_psel", PSEL, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) PREADY = 1'b1;
      chk("wait_access_psel", PSEL, 1);
      chk("wait_access_penable", PENABLE, 1);
      chk("wait_access_paddr", PADDR, 12'h010);
      chk("wait_access_rsp_valid", rsp_valid, 0);
      tick();
    end
    chk("wait_rsp_valid", rsp_valid, 1);
    chk("wait_rsp_rdata", rsp_rdata, 24'h654321);
    chk("wait_idle_psel", PSEL, 0);
    tick();
    chk("wait_rsp_pulse_end", rsp_valid, 0);
`endif

    // reset during ACCESS with a second command queued
    PREADY = 1'b1;
    PRDATA = 24'h777777;
    drive_cmd(1'b1, 1'b0, 12'h0AA, 24'h0);
    tick();
    drive_cmd(1'b1, 1'b1, 12'h0BB, 24'h0000BB);
    tick();
    drive_cmd(1'b0, 1'b0, '0, '0);
    tick();
    chk("rstmid_in_access", PENABLE, 1);
    chk("rstmid_queued", busy, 1);
    rst = 1'b1;
    drive_cmd(1'b1, 1'b1, 12'h0CC, 24'h0000CC);
    tick();
    rst = 1'b0;
    drive_cmd(1'b0, 1'b0, '0, '0);
    chk("rstmid_psel", PSEL, 0);
    chk("rstmid_penable", PENABLE, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rstmid_no_issue_psel", PSEL, 0);
      chk("rstmid_no_rsp", rsp_valid, 0);
    end

    // randomized traffic against an in-order queue model
    pend_rsp = 1'b0;
    pend_rdata = '0;
    model_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rnd_rsp_valid", rsp_valid, pend_rsp);
      if (pend_rsp) chk("rnd_rsp_rdata", rsp_rdata, pend_rdata);
      if (PENABLE && !PSEL) chk("rnd_penable_wo_psel", 1, 0);
      pend_rsp = 1'b0;
      PRDATA = 24'($urandom);
      PREADY = ($urandom_range(0, 3) != 0);
`ifdef APB_PREADY_EN
      ready_eff = PREADY;
`else
      ready_eff = 1'b1;
`endif
      if (PSEL && PENABLE && ready_eff) begin
        if (model_q.size() == 0) begin
          chk("rnd_unexpected_xfer", 1, 0);
        end else begin
          c = model_q.pop_front();
          chk("rnd_paddr", PADDR, c.addr);
          chk("rnd_pwrite", PWRITE, c.write);
          if (c.write) chk("rnd_pwdata", PWDATA, c.wdata);
          if (!c.write) begin
            pend_rsp = 1'b1;
            pend_rdata = PRDATA;
          end
        end
      end
      drive_cmd(($urandom_range(0, 2) != 0), 1'($urandom), 12'($urandom), 24'($urandom));
      if (cmd_valid && cmd_ready) begin
        c.write = cmd_write;
        c.addr  = cmd_addr;
        c.wdata = cmd_wdata;
        model_q.push_back(c);
      end
      chk("rnd_cmd_ready_model", cmd_ready, (model_q.size() - ((PSEL && !(PENABLE && ready_eff)) ? 1 : 0) - ((cmd_valid && cmd_ready) ? 1 : 0)) < 2);
      tick();
    end
    drive_cmd(1'b0, 1'b0, '0, '0);
    PREADY = 1'b1;
    n = 0;
    while ((model_q.size() != 0 || busy) && n < 200) begin
      if (PSEL && PENABLE && model_q.size() != 0) begin
        c = model_q.pop_front();
        chk("drain_paddr", PADDR, c.addr);
      end
      tick();
      n++;
    end
    chk("drain_bounded", (n < 200) ? 1 : 0, 1);
    chk("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter Amba_Word, default 24, data bus width in bits.
REQ-002 Parameter Amba_Addr_Depth, default 12, address bus width in bits.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-008 cmd_addr  input  Amba_Addr_Depth  target address.
REQ-009 cmd_wdata  input  Amba_Word  write data; ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle pulse, read data valid.
REQ-011 rsp_rdata  output  Amba_Word  captured PRDATA.
REQ-012 busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-013 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-014 PADDR  output  Amba_Addr_Depth; PWDATA  output  Amba_Word; PRDATA  input  Amba_Word.
REQ-015 PREADY  input  1  slave ready; used only under APB_PREADY_EN.

Function
REQ-016 Commands SHALL be accepted into a 2-entry FIFO on cmd_valid && cmd_ready; cmd_ready SHALL be 1 iff FIFO not full, independent of same-cycle pops.
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-018 IDLE->SETUP when FIFO non-empty: pop head, register PADDR/PWRITE/PWDATA, drive PSEL=1, PENABLE=0.
REQ-019 SETUP->ACCESS unconditionally; PSEL=1, PENABLE=1.
REQ-020 ACCESS completes on the cycle the completion condition (REQ-030/031) holds; on completion: FIFO non-empty -> SETUP with next command (PSEL stays 1, PENABLE=0); else -> IDLE (PSEL=0, PENABLE=0).
REQ-021 PADDR, PWRITE, PWDATA SHALL stay constant from SETUP through ACCESS completion and hold last values in IDLE.
REQ-022 Read completion SHALL register PRDATA into rsp_rdata and pulse rsp_valid for exactly one cycle the cycle after completion; writes SHALL produce no response.
REQ-023 rsp_rdata SHALL hold its value until the next read completion.
REQ-024 Latency: command accepted at edge N into empty FIFO with FSM IDLE -> SETUP in cycle N+1, ACCESS N+2, rsp_valid N+3 (zero wait states).
REQ-025 Back-to-back commands SHALL issue with no IDLE cycle between transfers.
REQ-026 Commands SHALL be issued strictly in acceptance order.

Reset
REQ-027 rst SHALL, at the next edge, clear FSM to IDLE, empty FIFO, and drive PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata to 0; cmd_ready=1, busy=0 after reset.
REQ-028 rst asserted mid-transfer SHALL abort it with no response and discard all queued commands.
REQ-029 rst SHALL dominate cmd_valid in the same cycle; no command is accepted.

Configuration
REQ-030 Macro APB_PREADY_EN defined: ACCESS completes only when PREADY=1; FSM holds ACCESS with all APB outputs stable while PREADY=0, no timeout.
REQ-031 APB_PREADY_EN undefined: PREADY is ignored; ACCESS always completes after one cycle.

Structure
REQ-032 Shared package SHALL hold Amba_Word/Amba_Addr_Depth defaults, the FSM state typedef, and the FIFO command record typedef (write, addr, wdata).
REQ-033 The FIFO SHALL be a sub-module apb_cmd_fifo (depth 2, push/pop/full/empty); all else in apb_master.

Verification
REQ-034 Single write addr 0x000 data 0x000001 -> PSEL 1 for 2 cycles, PENABLE only 2nd, PADDR 0x000, PWDATA 0x000001, PWRITE 1, no rsp_valid.
REQ-035 Read addr 0x004, slave PRDATA 0xABCDEF -> rsp_valid pulse at N+3, rsp_rdata 0xABCDEF held afterwards.
REQ-036 Three commands on consecutive cycles (W 0x001, W 0x002, R 0x003) -> cmd_ready 0 when 2 queued, transfers back-to-back in order, PSEL never drops between them.
REQ-037 APB_PREADY_EN defined, read with PREADY low 3 ACCESS cycles -> PADDR/PENABLE stable 4 ACCESS cycles, rsp_valid one cycle after PREADY=1.
REQ-038 rst during ACCESS with one command queued -> next cycle PSEL=0, PENABLE=0, busy=0, no rsp_valid, queued command never issued.
